fetch_buffer_unit: RTL and testbench
====================================

Name: fetch_buffer_unit

Overview:
- Instruction fetch stage directly upstream of the immediate sign extender and the decoder.
- Holds the PC and issues in-order requests to instruction memory with a valid/ready handshake.
- Buffers up to DEPTH returned instructions in a show-ahead FIFO.
- Presents the head instruction together with the pre-selected 12-bit immediate field and the ImmSrc select bit the extender consumes.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DEPTH, 2, buffer entries and maximum in-flight requests (power of two, 2..8).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  fetch address (current PC).
- imem_rsp_valid  in  1  response valid; responses return in order, at least 1 cycle after the request.
- imem_rsp_data  in  32  fetched instruction.
- redirect_valid  in  1  branch/jump redirect strobe.
- redirect_pc  in  32  new fetch PC.
- instr_valid  out  1  buffer head valid.
- instr_ready  in  1  downstream consumes head.
- instr_out  out  32  head instruction.
- instr_pc  out  32  PC of head instruction.
- imm_field  out  12  immediate field for the sign extender.
- imm_src  out  1  0 = I-type field, 1 = S-type field.

Behaviour:
- Reset values (async):
  - pc = RESET_PC; FIFO empty; outstanding = 0; discard = 0; state = HOLD.
  - All outputs 0, except imem_req_addr = RESET_PC.
- FSM:
  - HOLD: one cycle after rst deasserts, no request issued, then FETCH.
  - FETCH: normal operation.
  - DRAIN: entered on redirect when discard_next > 0; returns to FETCH when discard reaches 0.
- Requests:
  - imem_req_valid = (state != HOLD) && !redirect_valid && (count + outstanding < DEPTH).
  - imem_req_addr = pc.
  - On handshake: pc <= pc + 4 (wraps mod 2^32); outstanding increments.
  - Requests are allowed in DRAIN; credit counts discarded slots.
- Responses:
  - Each imem_rsp_valid decrements outstanding.
  - If discard > 0, the response is dropped and discard decrements.
  - Otherwise the response is pushed as {pc_of_request, data}. The per-request PC is tracked in a DEPTH-entry PC queue.
- Credit rule guarantees the FIFO never overflows.
  - Push and pop in the same cycle are legal at any occupancy.
  - A response arriving with no outstanding request is a protocol error; it is ignored and does not change outstanding.
- Output:
  - instr_valid = !empty.
  - Head is popped when instr_valid && instr_ready.
  - instr_out and instr_pc hold their values while not popped; they are 0 when empty.
- Immediate select (combinational from head):
  - opcode instr_out[6:0] == 7'b0100011 (store): imm_src = 1, imm_field = {instr_out[31:25], instr_out[11:7]}.
  - Otherwise: imm_src = 0, imm_field = instr_out[31:20].
  - Both are 0 when empty.
- Redirect (highest priority):
  - Same-cycle pop, push and request handshake are all ignored.
  - FIFO cleared; pc <= redirect_pc.
  - discard <= outstanding minus 1 if a response arrives that cycle, else outstanding; outstanding updated to match.
  - instr_valid = 0 from the next cycle.
  - A redirect during DRAIN re-computes discard the same way.
- Reset asserted mid-operation returns immediately to the reset values. In-flight responses arriving after reset are ignored by the error rule above.

Optional Feature:
- Macro: FETCH_MISALIGN_CHECK_EN.
- With the macro defined:
  - Adds output misalign_err (1 bit, reset 0).
  - A redirect with redirect_pc[1:0] != 0 sets misalign_err high and the state goes to HOLD. The FIFO is flushed and requests stop until the next redirect with an aligned PC, which clears misalign_err.
- Without the macro: port absent; redirect_pc[1:0] is forced to 0 when loaded into pc.

Test Plan:
- Reset, then imem_req_ready=1, 1-cycle memory returning 32'h00A00093 (addi) -> first request at cycle 2, addr 0x0. Then instr_valid, instr_pc=0x0, imm_src=0, imm_field=12'h00A.
- Head 32'hFE112E23 (sw) -> imm_src=1, imm_field=12'hFFC.
- Stall: instr_ready=0 for 10 cycles -> exactly DEPTH=2 requests (0x0, 0x4) issued; instr_out stable; no further requests until a pop.
- Redirect to 0x100 with 2 requests outstanding -> state DRAIN. Both old responses dropped, next instr_pc=0x100, no stale instruction delivered.
- Redirect in the same cycle as a response and a pop -> FIFO empty next cycle, discard = outstanding minus 1, first delivered instr_pc = redirect_pc.
- FETCH_MISALIGN_CHECK_EN defined, redirect to 0x102 -> misalign_err=1, no requests issued. Redirect to 0x200 -> misalign_err=0, fetch resumes at 0x200.

Source files
------------

// File: rtl/fetch_buffer_unit.sv
// Fetch stage: PC, in-order imem requests with credit control, show-ahead instruction buffer
// with I/S immediate pre-select. Optional `FETCH_MISALIGN_CHECK_EN adds misalign_err.
module fetch_buffer_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic [11:0] imm_field,
  output logic        imm_src
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);

  // state | meaning
  // HOLD  | no requests: first cycle after reset, or parked after a misaligned redirect
  // FETCH | normal fetching
  // DRAIN | fetching while responses issued before a redirect are dropped
  typedef enum logic [1:0] {HOLD = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int CW1 = CW + 1;
  localparam logic [CW:0] LIMIT = CW1'(DEPTH);

  state_t          state_q, state_d;
  logic [31:0]     pc_q;
  logic [CW-1:0]   count_q, outst_q, discard_q, discard_d;
  logic [AW-1:0]   f_wr_q, f_rd_q, p_wr_q, p_rd_q;
  logic [31:0]     f_data_q [DEPTH];
  logic [31:0]     f_pc_q   [DEPTH];
  logic [31:0]     pq_q     [DEPTH];

  logic req_fire, rsp_ok, push, pop, misalign, hold_lock;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic err_q;
  assign misalign     = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign hold_lock    = err_q;
  assign misalign_err = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else if (redirect_valid) err_q <= misalign;
  end
`else
  assign misalign  = 1'b0;
  assign hold_lock = 1'b0;
`endif

  // Credit covers both buffered entries and in-flight (including to-be-discarded) requests.
  assign imem_req_valid = (state_q != HOLD) && !redirect_valid &&
                          (({1'b0, count_q} + {1'b0, outst_q}) < LIMIT);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_ok         = imem_rsp_valid && (outst_q != '0);
  assign push           = rsp_ok && (discard_q == '0) && !redirect_valid;
  assign pop            = instr_valid && instr_ready && !redirect_valid;

  always_comb begin
    discard_d = discard_q;
    if (redirect_valid) discard_d = outst_q - CW'(rsp_ok);
    else if (rsp_ok && (discard_q != '0)) discard_d = discard_q - CW'(1);

    state_d = state_q;
    if (redirect_valid) begin
      if (misalign) state_d = HOLD;
      else if (discard_d != '0) state_d = DRAIN;
      else state_d = FETCH;
    end else begin
      case (state_q)
        HOLD:    if (!hold_lock) state_d = FETCH;
        DRAIN:   if (discard_d == '0) state_d = FETCH;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= HOLD;
      pc_q      <= RESET_PC;
      count_q   <= '0;
      outst_q   <= '0;
      discard_q <= '0;
      f_wr_q    <= '0;
      f_rd_q    <= '0;
      p_wr_q    <= '0;
      p_rd_q    <= '0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      if (req_fire) p_wr_q <= p_wr_q + AW'(1);
      if (rsp_ok) p_rd_q <= p_rd_q + AW'(1);
      if (redirect_valid) begin
        count_q <= '0;
        f_wr_q  <= '0;
        f_rd_q  <= '0;
        outst_q <= discard_d;
        if (!misalign) pc_q <= redirect_pc & ~32'h3;
      end else begin
        if (req_fire) pc_q <= pc_q + 32'd4;
        outst_q <= outst_q + CW'(req_fire) - CW'(rsp_ok);
        if (push) f_wr_q <= f_wr_q + AW'(1);
        if (pop) f_rd_q <= f_rd_q + AW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  // Payload storage needs no reset; outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      f_data_q[f_wr_q] <= imem_rsp_data;
      f_pc_q[f_wr_q]   <= pq_q[p_rd_q];
    end
    if (req_fire) pq_q[p_wr_q] <= pc_q;
  end

  assign instr_valid = (count_q != '0);
  assign instr_out   = instr_valid ? f_data_q[f_rd_q] : 32'h0;
  assign instr_pc    = instr_valid ? f_pc_q[f_rd_q] : 32'h0;
  assign imm_src     = (instr_out[6:0] == 7'b0100011);
  assign imm_field   = imm_src ? {instr_out[31:25], instr_out[11:7]} : instr_out[31:20];

endmodule

// File: tb/tb_fetch_buffer_unit.sv
// Self-checking bench for fetch_buffer_unit: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_fetch_buffer_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr_out, instr_pc;
  logic [11:0] imm_field;
  logic        imm_src;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  fetch_buffer_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out), .instr_pc(instr_pc),
    .imm_field(imm_field), .imm_src(imm_src)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory environment ----------------
  logic [31:0] mem_q[$];
  int  req_count = 0;
  logic [31:0] last_req_addr = 32'h0;
  bit  mem_en = 1'b1;
  bit  directed = 1'b1;
  int  mem_pct = 100;
  int  spur_pct = 0;

  function automatic logic [31:0] dir_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A00093;
    if (a == 32'h4) return 32'hFE112E23;
    return {a[23:0], 8'h13};
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(0, 2) == 0) w[6:0] = 7'b0100011;
    return w;
  endfunction

  always @(negedge clk) begin
    if (!rst && imem_req_valid && imem_req_ready) begin
      mem_q.push_back(imem_req_addr);
      req_count++;
      last_req_addr = imem_req_addr;
    end
  end

  task automatic mem_drive();
    logic [31:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    if (mem_q.size() > 0) begin
      if (mem_en && ($urandom_range(0, 99) < mem_pct)) begin
        a = mem_q.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = directed ? dir_word(a) : rand_word();
      end
    end else if (spur_pct > 0 && ($urandom_range(0, 99) < spur_pct)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    mem_drive();
  endtask

  // ---------------- reference model + per-cycle compare ----------------
  logic [31:0] m_reqq[$];
  logic [31:0] m_fd[$];
  logic [31:0] m_fp[$];
  int          m_disc = 0;
  bit          m_hold = 1'b1;
  bit          m_err = 1'b0;
  logic [31:0] m_pc = RESET_PC;

  always @(negedge clk) begin
    bit          ev, erv, ok, fire, is_st;
    logic [31:0] eo, ep, rp;
    logic [11:0] ef;
    if (rst) begin
      m_reqq.delete(); m_fd.delete(); m_fp.delete();
      m_disc = 0; m_hold = 1'b1; m_err = 1'b0; m_pc = RESET_PC;
    end
    ev    = (m_fd.size() != 0);
    eo    = ev ? m_fd[0] : 32'h0;
    ep    = ev ? m_fp[0] : 32'h0;
    is_st = (eo[6:0] == 7'b0100011);
    ef    = is_st ? {eo[31:25], eo[11:7]} : eo[31:20];
    erv   = !rst && !m_hold && !redirect_valid && ((m_fd.size() + m_reqq.size()) < DEPTH);
    chk1("instr_valid", instr_valid, ev);
    chk("instr_out", instr_out, eo);
    chk("instr_pc", instr_pc, ep);
    chk("imm_field", 32'(imm_field), 32'(ef));
    chk1("imm_src", imm_src, is_st);
    chk1("req_valid", imem_req_valid, erv);
    chk("req_addr", imem_req_addr, m_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk1("misalign_err", misalign_err, m_err);
`endif
    if (!rst) begin
      fire = erv && imem_req_ready;
      ok   = imem_rsp_valid && (m_reqq.size() != 0);
      rp   = 32'h0;
      if (ok) rp = m_reqq.pop_front();
      if (redirect_valid) begin
        m_fd.delete(); m_fp.delete();
        m_disc = m_reqq.size();
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect_pc[1:0] != 2'b00) begin
          m_err = 1'b1; m_hold = 1'b1;
        end else begin
          m_err = 1'b0; m_hold = 1'b0; m_pc = redirect_pc;
        end
`else
        m_hold = 1'b0;
        m_pc = {redirect_pc[31:2], 2'b00};
`endif
      end else begin
        if (ev && instr_ready) begin
          void'(m_fd.pop_front());
          void'(m_fp.pop_front());
        end
        if (ok) begin
          if (m_disc > 0) m_disc--;
          else begin
            m_fd.push_back(imem_rsp_data);
            m_fp.push_back(rp);
          end
        end
        if (fire) begin
          m_reqq.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
        if (m_hold && !m_err) m_hold = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_first_valid(input string name, input logic [31:0] exp_pc);
    int n;
    n = 0;
    while (!instr_valid && n < 30) begin
      step();
      n++;
    end
    chk1({name, "_valid"}, instr_valid, 1'b1);
    chk({name, "_pc"}, instr_pc, exp_pc);
  endtask

  initial begin
    int n;
    int rc;
    logic [31:0] rpc;

    repeat (3) step();
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_instr_out", instr_out, 32'h0);

    imem_req_ready = 1'b1;
    instr_ready = 1'b0;
    rst = 1'b0;
    chk1("hold_no_req", imem_req_valid, 1'b0);
    step();
    chk1("first_req_valid", imem_req_valid, 1'b1);
    chk("first_req_addr", imem_req_addr, 32'h0);

    wait_first_valid("addi", 32'h0);
    chk("addi_out", instr_out, 32'h00A00093);
    chk("addi_imm", 32'(imm_field), 32'h00A);
    chk1("addi_src", imm_src, 1'b0);

    repeat (10) step();
    chk("stall_req_count", 32'(req_count), 32'd2);
    chk("stall_last_addr", last_req_addr, 32'h4);
    chk("stall_head_stable", instr_out, 32'h00A00093);
    chk1("stall_no_req", imem_req_valid, 1'b0);

    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    chk("sw_pc", instr_pc, 32'h4);
    chk("sw_imm", 32'(imm_field), 32'hFFC);
    chk1("sw_src", imm_src, 1'b1);

    // Hold memory so two requests sit in flight, then redirect past them.
    mem_en = 1'b0;
    instr_ready = 1'b1;
    repeat (8) step();
    chk1("pre_redir_empty", instr_valid, 1'b0);
    chk1("pre_redir_credit", imem_req_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    mem_en = 1'b1;
    wait_first_valid("redir", 32'h100);
    chk("redir_out", instr_out, dir_word(32'h100));

    // Redirect in the same cycle as a response and a pop.
    n = 0;
    while (!(instr_valid && imem_rsp_valid) && n < 20) begin
      step();
      n++;
    end
    chk1("combo_setup", instr_valid && imem_rsp_valid, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    step();
    redirect_valid = 1'b0;
    chk1("combo_empty", instr_valid, 1'b0);
    wait_first_valid("combo", 32'h300);

`ifdef FETCH_MISALIGN_CHECK_EN
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0;
    chk1("misalign_set", misalign_err, 1'b1);
    rc = req_count;
    repeat (6) step();
    chk("misalign_no_req", 32'(req_count - rc), 32'd0);
    chk1("misalign_empty", instr_valid, 1'b0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk1("misalign_clr", misalign_err, 1'b0);
    wait_first_valid("realign", 32'h200);
`endif

    // Randomized traffic with occasional mid-run reset.
    directed = 1'b0;
    mem_pct = 60;
    spur_pct = 5;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        mem_q.delete();
        imem_rsp_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data = $urandom;
      end else begin
        step();
        instr_ready = ($urandom_range(0, 3) != 0);
        imem_req_ready = ($urandom_range(0, 3) != 0);
        redirect_valid = ($urandom_range(0, 24) == 0);
        case ($urandom_range(0, 7))
          0: rpc = 32'hFFFF_FFF8;
          1: rpc = $urandom | 32'h1;
          2: rpc = RESET_PC;
          default: rpc = $urandom & ~32'h3;
        endcase
        redirect_pc = rpc;
      end
    end
    step();
    redirect_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
